// File: rtl/regfile_sb.sv
// Parametrised integer register file with write-through bypass and a per-register
// pending scoreboard; clears its storage one register per cycle after reset.
module regfile_sb #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32,
    localparam int unsigned AW   = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_val,
    output logic [XLEN-1:0] rs2_val,
    output logic            rs1_busy,
    output logic            rs2_busy,
    input  logic            iss_en,
    input  logic [AW-1:0]   iss_rd,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data,
    output logic            ready
);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [AW-1:0]     cnt;
    logic [NREGS-1:0]  pending;
    logic [XLEN-1:0]   mem [NREGS];

    logic run;
    logic wr_ok;
    logic iss_ok;
    logic rs1_ok;
    logic rs2_ok;
    logic rs1_hit;
    logic rs2_hit;

    // Non-zero and inside the architectural register range.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (a != '0) && ({1'b0, a} < (AW+1)'(NREGS));
    endfunction

    assign run     = (state == RUN);
    assign wr_ok   = run && wr_en && addr_ok(wr_addr);
    assign iss_ok  = run && iss_en && addr_ok(iss_rd);
    assign rs1_ok  = run && addr_ok(rs1_addr);
    assign rs2_ok  = run && addr_ok(rs2_addr);
    assign rs1_hit = wr_ok && (wr_addr == rs1_addr);
    assign rs2_hit = wr_ok && (wr_addr == rs2_addr);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: leave CLEAR on the edge that writes the last register.
    always_comb begin
        state_nxt = state;
        case (state)
            CLEAR:   if (cnt == AW'(NREGS - 1)) state_nxt = RUN;
            RUN:     state_nxt = RUN;
            default: state_nxt = CLEAR;
        endcase
    end

    // Output logic: ports are forced quiet until the sweep completes.
    always_comb begin
        ready    = run;
        rs1_val  = '0;
        rs2_val  = '0;
        rs1_busy = 1'b0;
        rs2_busy = 1'b0;
        if (rs1_ok) begin
            rs1_val  = rs1_hit ? wr_data : mem[rs1_addr];
            rs1_busy = pending[rs1_addr] && !rs1_hit;
        end
        if (rs2_ok) begin
            rs2_val  = rs2_hit ? wr_data : mem[rs2_addr];
            rs2_busy = pending[rs2_addr] && !rs2_hit;
        end
    end

    // Sweep counter; x0 is never stored so the sweep starts at 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= AW'(1);
        end else if (state == CLEAR) begin
            cnt <= cnt + AW'(1);
        end
    end

    // Storage has no reset so it can map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) begin
                mem[cnt] <= '0;
            end else if (wr_ok) begin
                mem[wr_addr] <= wr_data;
            end
        end
    end

    // Issue is applied after writeback so a same-cycle issue keeps the bit set.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
        end else begin
            if (wr_ok) pending[wr_addr] <= 1'b0;
            if (iss_ok) pending[iss_rd] <= 1'b1;
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: reset sweep, bypass, x0, scoreboard,
// collisions, and a 24-register instance with a mid-sweep reset.
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic        rst24;
    logic [4:0]  rs1_addr, rs2_addr, iss_rd, wr_addr;
    logic        iss_en, wr_en;
    logic [31:0] wr_data;
    logic [31:0] rs1_val, rs2_val, rs1_val24, rs2_val24;
    logic        rs1_busy, rs2_busy, rs1_busy24, rs2_busy24;
    logic        ready, ready24;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_sb u_dut (
        .clk(clk), .rst(rst),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_val(rs1_val), .rs2_val(rs2_val),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .iss_en(iss_en), .iss_rd(iss_rd),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .ready(ready)
    );

    regfile_sb #(.XLEN(32), .NREGS(24)) u_dut24 (
        .clk(clk), .rst(rst24),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_val(rs1_val24), .rs2_val(rs2_val24),
        .rs1_busy(rs1_busy24), .rs2_busy(rs2_busy24),
        .iss_en(iss_en), .iss_rd(iss_rd),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .ready(ready24)
    );

    typedef struct {
        logic [4:0]  a1, a2;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        ie;
        logic [4:0]  ir;
        logic [31:0] v1, v2;
        logic        b1, b2;
    } vec_t;

    typedef struct {
        int          idx;
        logic [31:0] v1, v2;
        logic        b1, b2;
    } exp_t;

    vec_t vecs[16];
    exp_t sb[$];

    function automatic vec_t mk(input logic [4:0] a1, input logic [4:0] a2,
                                input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                input logic ie, input logic [4:0] ir,
                                input logic [31:0] v1, input logic [31:0] v2,
                                input logic b1, input logic b2);
        vec_t v;
        v.a1 = a1; v.a2 = a2; v.we = we; v.wa = wa; v.wd = wd;
        v.ie = ie; v.ir = ir; v.v1 = v1; v.v2 = v2; v.b1 = b1; v.b2 = b2;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic idle();
        wr_en = 1'b0; iss_en = 1'b0;
        wr_addr = '0; iss_rd = '0; wr_data = '0;
    endtask

    // Counts rising edges until rdy is seen high, bounded.
    task automatic wait_ready(input bit use24, output int n);
        n = 0;
        while (n < 100) begin
            @(posedge clk);
            n++;
            #1;
            if ((use24 ? ready24 : ready) === 1'b1) break;
        end
    endtask

    initial begin
        int n;
        exp_t e;

        vecs[0]  = mk(7, 7, 1, 7, 32'hDEADBEEF, 0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0);
        vecs[1]  = mk(7, 7, 0, 0, 32'h0,        0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0);
        vecs[2]  = mk(0, 7, 1, 0, 32'hFFFFFFFF, 1, 0, 32'h0,        32'hDEADBEEF, 0, 0);
        vecs[3]  = mk(0, 0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        0, 0);
        vecs[4]  = mk(3, 7, 0, 0, 32'h0,        1, 3, 32'h0,        32'hDEADBEEF, 0, 0);
        vecs[5]  = mk(3, 3, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        1, 1);
        vecs[6]  = mk(3, 0, 1, 3, 32'h12,       0, 0, 32'h12,       32'h0,        0, 0);
        vecs[7]  = mk(3, 3, 0, 0, 32'h0,        0, 0, 32'h12,       32'h12,       0, 0);
        vecs[8]  = mk(3, 4, 0, 0, 32'h0,        1, 4, 32'h12,       32'h0,        0, 0);
        vecs[9]  = mk(4, 4, 1, 4, 32'h55,       1, 4, 32'h55,       32'h55,       0, 0);
        vecs[10] = mk(3, 4, 0, 0, 32'h0,        0, 0, 32'h12,       32'h55,       0, 1);
        vecs[11] = mk(4, 0, 0, 0, 32'h0,        1, 4, 32'h55,       32'h0,        1, 0);
        vecs[12] = mk(4, 4, 1, 4, 32'h66,       0, 0, 32'h66,       32'h66,       0, 0);
        vecs[13] = mk(4, 3, 0, 0, 32'h0,        0, 0, 32'h66,       32'h12,       0, 0);
        vecs[14] = mk(31, 30, 1, 31, 32'h31313131, 1, 30, 32'h31313131, 32'h0,    0, 0);
        vecs[15] = mk(31, 30, 0, 0, 32'h0,      0, 0, 32'h31313131, 32'h0,        0, 1);

        // Reset: two cycles, outputs quiet.
        idle();
        rst = 1'b1; rst24 = 1'b1;
        rs1_addr = 5; rs2_addr = 7;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(ready), 32'h0);
        check("rst_rs1_val", rs1_val, 32'h0);
        check("rst_rs2_busy", 32'(rs2_busy), 32'h0);

        // Sweep with a write to x5 that must be ignored.
        @(negedge clk);
        rst = 1'b0;
        wr_en = 1'b1; wr_addr = 5; wr_data = 32'hAAAA5555;
        #1;
        check("sweep_rs1_val", rs1_val, 32'h0);
        wait_ready(1'b0, n);
        wr_en = 1'b0;
        check("sweep_len", 32'(n), 32'd31);

        // Every address reads zero and idle.
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            rs1_addr = 5'(i); rs2_addr = 5'(31 - i);
            #1;
            check($sformatf("zero_rs1_x%0d", i), rs1_val, 32'h0);
            check($sformatf("zero_rs2_x%0d", 31 - i), rs2_val, 32'h0);
            check($sformatf("idle_busy_x%0d", i), 32'({rs1_busy, rs2_busy}), 32'h0);
        end

        // Vector table: push expectation on drive, pop and compare before the edge.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            rs1_addr = vecs[i].a1; rs2_addr = vecs[i].a2;
            wr_en = vecs[i].we; wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
            iss_en = vecs[i].ie; iss_rd = vecs[i].ir;
            sb.push_back('{idx: i, v1: vecs[i].v1, v2: vecs[i].v2, b1: vecs[i].b1, b2: vecs[i].b2});
            #1;
            e = sb.pop_front();
            check($sformatf("vec%0d_rs1_val", e.idx), rs1_val, e.v1);
            check($sformatf("vec%0d_rs2_val", e.idx), rs2_val, e.v2);
            check($sformatf("vec%0d_rs1_busy", e.idx), 32'(rs1_busy), 32'(e.b1));
            check($sformatf("vec%0d_rs2_busy", e.idx), 32'(rs2_busy), 32'(e.b2));
        end
        @(negedge clk);
        idle();

        // Reset in RUN clears pending and restarts the sweep.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rs1_addr = 30; rs2_addr = 4;
        #1;
        check("rerun_ready_low", 32'(ready), 32'h0);
        wait_ready(1'b0, n);
        check("rerun_sweep_len", 32'(n), 32'd31);
        check("rerun_x30_busy", 32'(rs1_busy), 32'h0);
        check("rerun_x4_val", rs2_val, 32'h0);

        // 24-register instance: reset at sweep cycle 10 restarts the count.
        @(negedge clk);
        rst24 = 1'b1;
        @(negedge clk);
        rst24 = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("r24_mid_ready", 32'(ready24), 32'h0);
        @(negedge clk);
        rst24 = 1'b1;
        @(negedge clk);
        rst24 = 1'b0;
        wait_ready(1'b1, n);
        check("r24_sweep_len", 32'(n), 32'd23);

        // Out-of-range writes/issues are ignored; x23 is live.
        for (int a = 23; a < 32; a++) begin
            @(negedge clk);
            wr_en = 1'b1; wr_addr = 5'(a); wr_data = 32'h1000_0000 + 32'(a);
            iss_en = 1'b1; iss_rd = 5'(a);
            rs1_addr = 5'(a); rs2_addr = 5'(a);
            #1;
            check($sformatf("r24_byp_x%0d", a), rs1_val24, (a == 23) ? 32'h1000_0017 : 32'h0);
        end
        @(negedge clk);
        idle();
        for (int a = 23; a < 32; a++) begin
            @(negedge clk);
            rs1_addr = 5'(a); rs2_addr = 5'(a);
            #1;
            check($sformatf("r24_val_x%0d", a), rs2_val24, (a == 23) ? 32'h1000_0017 : 32'h0);
            check($sformatf("r24_busy_x%0d", a), 32'(rs1_busy24), (a == 23) ? 32'h1 : 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised integer register file with write-through bypass and a per-register pending scoreboard, replacing the fixed 32-bit/2-read register file in the CPU core. Sits between decode (read and issue) and writeback (write). After reset it clears its storage with a one-register-per-cycle sweep so the array can map to distributed RAM. Decode uses the busy flags to detect RAW hazards against in-flight producers.

## Interface
- XLEN, 32, data width in bits
- NREGS, 32, number of architectural registers including x0; range 2..64
- AW, $clog2(NREGS), register address width; derived, not overridden
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- rs1_addr  in  AW  read port 1 address
- rs2_addr  in  AW  read port 2 address
- rs1_val  out  XLEN  read port 1 data, combinational
- rs2_val  out  XLEN  read port 2 data, combinational
- rs1_busy  out  1  register at rs1_addr has an outstanding producer
- rs2_busy  out  1  register at rs2_addr has an outstanding producer
- iss_en  in  1  decode issues an instruction that will write iss_rd
- iss_rd  in  AW  destination register of the issued instruction
- wr_en  in  1  writeback valid
- wr_addr  in  AW  writeback destination
- wr_data  in  XLEN  writeback data
- ready  out  1  high when the clear sweep is done and ports are live

## Operation
- States: CLEAR, RUN. Reset is synchronous and active-high: rst=1 forces state CLEAR, sweep counter cnt=1, all pending bits 0.
- CLEAR: each cycle with rst=0, write 0 to reg[cnt] and increment cnt. When cnt==NREGS-1 the write happens and state moves to RUN on the same edge.
- CLEAR: ready=0, rs*_val=0, rs*_busy=0. wr_en and iss_en are ignored.
- rst reasserted mid-sweep or in RUN: the sweep restarts from cnt=1, and all pending bits clear.
- RUN: ready=1.
- x0 is never stored. Reads of address 0 return 0 with busy=0. Writes and issues to address 0 are ignored.
- Addresses >= NREGS (non-power-of-2 NREGS): reads return 0 with busy=0; writes and issues are ignored.
- Write: if wr_en and wr_addr is valid and non-zero, reg[wr_addr] <= wr_data at the edge, and pending[wr_addr] clears.
- Bypass: if wr_en and wr_addr==rsN_addr (non-zero, valid), rsN_val = wr_data in the same cycle. Otherwise rsN_val = reg[rsN_addr].
- Busy: rsN_busy = pending[rsN_addr] AND NOT (wr_en AND wr_addr==rsN_addr). A same-cycle writeback resolves the hazard.
- Issue: if iss_en with valid non-zero iss_rd, pending[iss_rd] <= 1.
- iss_en and wr_en to the same register in the same cycle: issue wins and pending stays 1, because the new producer supersedes the old one. Same-cycle busy still reads 0, since the issued instruction has not been read yet.
- Issue to an already-pending register: stays 1. There is no count and no error.
- Power-up with no rst: contents are undefined. rst is mandatory before use.

## Timing
- Read data and busy: combinational from addresses, wr_* and state; zero-cycle latency.
- Write visible through array reads one cycle after wr_en, and in the same cycle via the bypass.
- pending set or clear visible one cycle after the issuing or writing edge.
- Sweep length: ready rises exactly NREGS-1 cycles after the first cycle with rst=0 (31 cycles at the default).
- Reset values: ready=0, rs1_val=rs2_val=0, rs1_busy=rs2_busy=0, all pending=0. After the sweep, every register reads 0.

## Test plan
- Reset sweep: rst for 2 cycles, then release, then count cycles. Required: ready=1 exactly 31 cycles later, all 32 addresses read 0x00000000 with busy=0, and wr_en=1 to x5 during the sweep leaves x5=0.
- Bypass: in RUN, wr_en x7=0xDEADBEEF with rs1_addr=rs2_addr=7 in the same cycle. Required: both ports read 0xDEADBEEF that cycle and the next cycle with wr_en=0.
- x0 protection: wr_en x0=0xFFFFFFFF and iss_en x0, then read x0. Required: val 0, busy 0.
- Scoreboard: iss_en rd=3, then rs1_addr=3. Required: rs1_busy=1 next cycle. Then wr x3=0x12 with rs1_addr=3. Required: busy=0 and val=0x12 that cycle, and pending stays cleared afterwards.
- Collision: pending[4]=1, then iss_en rd=4 and wr_en x4=0x55 in the same cycle. Required: next cycle rs2_addr=4 reads 0x55 with busy=1.
- Reset mid-sweep and NREGS=24: rst at sweep cycle 10. Required: ready rises 23 cycles after release, and addresses 24..31 read 0 with busy=0.
